// File: rtl/interval_timer_pkg.sv
// Shared register map, bit positions and CONTROL field layout for the
// multi-channel interval timer.
package interval_timer_pkg;

    localparam logic [2:0] OFF_STATUS   = 3'd0;
    localparam logic [2:0] OFF_CONTROL  = 3'd1;
    localparam logic [2:0] OFF_PERIOD   = 3'd2;
    localparam logic [2:0] OFF_SNAPSHOT = 3'd3;
    localparam logic [2:0] OFF_PRESCALE = 3'd4;

    localparam int STAT_TO  = 0;
    localparam int STAT_RUN = 1;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    // Only the stored CONTROL bits; START/STOP are strobes and never held.
    typedef struct packed {
        logic cont;
        logic ito;
    } ctrl_t;

endpackage

// File: rtl/interval_timer_channel.sv
// One timer channel: period/prescale/control registers, prescaled
// down-counter, timeout flag, snapshot capture and read-back mux.
module interval_timer_channel
    import interval_timer_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int COUNT_W      = 32,
    parameter int PRESC_W      = 16,
    parameter int RESET_PERIOD = 99999
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_status,
    input  logic              wr_control,
    input  logic              wr_period,
    input  logic              wr_snapshot,
    input  logic              wr_prescale,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        rd_offset,
    output logic [DATA_W-1:0] rd_data,
    output logic              irq_ch
);

    logic [COUNT_W-1:0] period_q;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] snap_q;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] pcnt_q;
    ctrl_t              ctrl_q;
    logic               run_q;
    logic               to_q;
    logic               zero_d_q;
    logic               reload_q;

    logic tick;
    logic cnt_zero;
    logic to_event;

    assign tick     = run_q && (pcnt_q == '0);
    assign cnt_zero = (count_q == '0);
    assign to_event = cnt_zero && !zero_d_q;
    assign irq_ch   = to_q && ctrl_q.ito;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_q <= COUNT_W'(RESET_PERIOD);
            count_q  <= COUNT_W'(RESET_PERIOD);
            snap_q   <= '0;
            presc_q  <= '0;
            pcnt_q   <= '0;
            ctrl_q   <= '0;
            run_q    <= 1'b0;
            to_q     <= 1'b0;
            zero_d_q <= (RESET_PERIOD == 0);
            reload_q <= 1'b0;
        end else begin
            zero_d_q <= cnt_zero;
            reload_q <= wr_period;

            if (run_q)
                pcnt_q <= (pcnt_q == '0) ? presc_q : pcnt_q - PRESC_W'(1);

            if (tick) begin
                if (cnt_zero) begin
                    count_q <= period_q;
                    if (!ctrl_q.cont)
                        run_q <= 1'b0;
                end else begin
                    count_q <= count_q - COUNT_W'(1);
                end
            end

            // A timeout in the same cycle as a STATUS write must not be lost.
            if (to_event)
                to_q <= 1'b1;
            else if (wr_status)
                to_q <= 1'b0;

            if (wr_control) begin
                ctrl_q.ito  <= wdata[CTRL_ITO];
                ctrl_q.cont <= wdata[CTRL_CONT];
                if (wdata[CTRL_START]) begin
                    run_q <= 1'b1;
                    if (!run_q)
                        pcnt_q <= presc_q;
                end else if (wdata[CTRL_STOP]) begin
                    run_q <= 1'b0;
                end
            end

            if (wr_period) begin
                period_q <= wdata[COUNT_W-1:0];
                run_q    <= 1'b0;
            end

            // Force-reload one cycle after a PERIOD write picks up the new value.
            if (reload_q) begin
                count_q <= period_q;
                pcnt_q  <= presc_q;
            end

            if (wr_snapshot)
                snap_q <= count_q;

            if (wr_prescale)
                presc_q <= wdata[PRESC_W-1:0];
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_offset)
            OFF_STATUS: begin
                rd_data[STAT_TO]  = to_q;
                rd_data[STAT_RUN] = run_q;
            end
            OFF_CONTROL: begin
                rd_data[CTRL_ITO]  = ctrl_q.ito;
                rd_data[CTRL_CONT] = ctrl_q.cont;
            end
            OFF_PERIOD:   rd_data[COUNT_W-1:0] = period_q;
            OFF_SNAPSHOT: rd_data[COUNT_W-1:0] = snap_q;
            OFF_PRESCALE: rd_data[PRESC_W-1:0] = presc_q;
            default:      rd_data = '0;
        endcase
    end

endmodule

// File: rtl/interval_timer_mc.sv
// Avalon-MM slave wrapping NUM_CH independent interval timer channels:
// address decode, registered read mux and combined interrupt.
module interval_timer_mc
    import interval_timer_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int COUNT_W      = 32,
    parameter int DATA_W       = 32,
    parameter int PRESC_W      = 16,
    parameter int RESET_PERIOD = 99999,
    parameter int ADDR_W       = $clog2(NUM_CH) + 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_ch
);

    logic              wr_en;
    logic [ADDR_W-1:0] ch_idx;
    logic [2:0]        offset;
    logic [DATA_W-1:0] ch_rd [NUM_CH];
    logic [DATA_W-1:0] rd_next;

    assign wr_en  = chipselect && !write_n;
    assign ch_idx = address >> 3;
    assign offset = address[2:0];
    assign irq    = |irq_ch;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = wr_en && (ch_idx == ADDR_W'(i));

        interval_timer_channel #(
            .DATA_W       (DATA_W),
            .COUNT_W      (COUNT_W),
            .PRESC_W      (PRESC_W),
            .RESET_PERIOD (RESET_PERIOD)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .wr_status   (sel && (offset == OFF_STATUS)),
            .wr_control  (sel && (offset == OFF_CONTROL)),
            .wr_period   (sel && (offset == OFF_PERIOD)),
            .wr_snapshot (sel && (offset == OFF_SNAPSHOT)),
            .wr_prescale (sel && (offset == OFF_PRESCALE)),
            .wdata       (writedata),
            .rd_offset   (offset),
            .rd_data     (ch_rd[i]),
            .irq_ch      (irq_ch[i])
        );
    end

    // Unimplemented channel indices fall through to zero.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_idx == ADDR_W'(i))
                rd_next = ch_rd[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            readdata <= '0;
        else
            readdata <= rd_next;
    end

endmodule

// File: tb/tb_interval_timer_mc.sv
// Directed bench for interval_timer_mc with a timeline-based reference model
// checked every cycle plus hand-computed literal expectations.
module tb_interval_timer_mc;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [4:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;
    logic [3:0]  irq_ch;

    interval_timer_mc dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write_n    (write_n),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .irq_ch     (irq_ch)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d required<20000", cyc);
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Count value after an edge is derived from elapsed time since the
    // channel was started: ticks = elapsed/(P+1), then wrap through PERIOD.
    int unsigned m_period[NCH], m_presc[NCH], m_p0[NCH], m_base[NCH];
    int unsigned m_hold[NCH], m_snap[NCH], m_prev1[NCH], m_prev2[NCH];
    int          m_t0[NCH], m_reload_at[NCH];
    bit          m_ito[NCH], m_cont[NCH], m_to[NCH], m_run[NCH];
    logic [3:0]  exp_irq = '0;

    function automatic int unsigned run_count(input int ch, input int t);
        int unsigned ticks;
        ticks = int'(t - m_t0[ch]) / (m_p0[ch] + 1);
        if (ticks <= m_base[ch])
            return m_base[ch] - ticks;
        return m_period[ch] - ((ticks - m_base[ch] - 1) % (m_period[ch] + 1));
    endfunction

    function automatic logic [31:0] read_value(input int ch, input int off);
        case (off)
            0: return {30'd0, m_run[ch], m_to[ch]};
            1: return {30'd0, m_cont[ch], m_ito[ch]};
            2: return m_period[ch];
            3: return m_snap[ch];
            4: return m_presc[ch];
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_period[c] = 99999; m_presc[c] = 0; m_p0[c] = 0; m_base[c] = 0;
                m_hold[c] = 99999; m_snap[c] = 0; m_prev1[c] = 99999; m_prev2[c] = 99999;
                m_t0[c] = 0; m_reload_at[c] = -1;
                m_ito[c] = 0; m_cont[c] = 0; m_to[c] = 0; m_run[c] = 0;
            end
            exp_irq = '0;
            exp_q.delete();
        end else begin
            int t, a_ch, a_off;
            bit wr;
            int unsigned cnow;
            t     = cyc + 1;
            a_ch  = int'(address[4:3]);
            a_off = int'(address[2:0]);
            wr    = chipselect && !write_n;
            exp_q.push_back(read_value(a_ch, a_off));
            for (int c = 0; c < NCH; c++) begin
                bit hit;
                hit = wr && (a_ch == c);
                if (m_run[c])
                    cnow = run_count(c, t);
                else if (m_reload_at[c] == t)
                    cnow = m_period[c];
                else
                    cnow = m_hold[c];
                if (m_prev1[c] == 0 && m_prev2[c] != 0)
                    m_to[c] = 1;
                else if (hit && a_off == 0)
                    m_to[c] = 0;
                if (m_run[c] && !m_cont[c] &&
                    (int'(t - m_t0[c]) / (m_p0[c] + 1)) > m_base[c])
                    m_run[c] = 0;
                if (hit) begin
                    case (a_off)
                        1: begin
                            m_ito[c]  = writedata[0];
                            m_cont[c] = writedata[1];
                            if (writedata[2]) begin
                                if (!m_run[c]) begin
                                    m_run[c] = 1; m_t0[c] = t; m_base[c] = cnow; m_p0[c] = m_presc[c];
                                end
                            end else if (writedata[3]) begin
                                m_run[c] = 0;
                            end
                        end
                        2: begin
                            m_run[c] = 0; m_period[c] = writedata; m_reload_at[c] = t + 1;
                        end
                        3: m_snap[c] = m_prev1[c];
                        4: m_presc[c] = writedata[15:0];
                        default: ;
                    endcase
                end
                if (!m_run[c]) m_hold[c] = cnow;
                m_prev2[c] = m_prev1[c];
                m_prev1[c] = cnow;
                exp_irq[c] = m_to[c] && m_ito[c];
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            check("readdata", readdata, exp_q.pop_front());
            check("irq_ch", {28'd0, irq_ch}, {28'd0, exp_irq});
            check("irq", {31'd0, irq}, {31'd0, |exp_irq});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic bus_write(input int ch, input int off, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = 5'(ch * 8 + off); writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input int ch, input int off, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b1; address = 5'(ch * 8 + off);
        @(posedge clk);
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_edge(input int e);
        while (cyc < e - 1) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rise(input int idx, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (irq_ch[idx]) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL irq_ch[%0d]_rise: no rise within %0d cycles, required a rise", idx, budget);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [31:0] rd, v1;
        int n, at;

        repeat (3) @(posedge clk);
        #1;
        check("reset_readdata", readdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        @(negedge clk); #1;
        reset = 1'b0;

        bus_read(0, 2, rd);
        check("ch0_period_reset", rd, 32'd99999);
        check("irq_idle", {31'd0, irq}, 32'd0);

        // ch1: continuous, PERIOD=9, PRESCALE=0 -> 10-cycle timeouts
        bus_write(1, 2, 32'd9);
        bus_write(1, 4, 32'd0);
        bus_write(1, 1, 32'h7);
        n = cyc;
        wait_rise(1, 40, at);
        check("ch1_first_rise", at - n, 32'd10);
        wait_edge(n + 11);
        bus_write(1, 0, 32'd0);
        wait_rise(1, 40, at);
        check("ch1_second_rise", at - n, 32'd20);
        wait_edge(n + 21);
        bus_write(1, 0, 32'd0);
        check("ch1_cleared", {31'd0, irq_ch[1]}, 32'd0);
        wait_edge(n + 30);
        bus_write(1, 0, 32'd0);
        check("ch1_clear_vs_timeout", {31'd0, irq_ch[1]}, 32'd1);
        bus_write(1, 1, 32'h8);

        // ch2: one-shot, PERIOD=3, PRESCALE=4
        bus_write(2, 2, 32'd3);
        bus_write(2, 4, 32'd4);
        bus_write(2, 1, 32'h5);
        n = cyc;
        wait_rise(2, 40, at);
        check("ch2_rise", at - n, 32'd16);
        wait_edge(n + 25);
        bus_read(2, 0, rd);
        check("ch2_status_done", rd, 32'h1);
        bus_write(2, 3, 32'd0);
        bus_read(2, 3, rd);
        check("ch2_count_holds", rd, 32'd3);
        bus_write(2, 0, 32'd0);
        wait_cycles(30);
        check("ch2_no_second_timeout", {31'd0, irq_ch[2]}, 32'd0);

        // ch0: PERIOD write while running stops and reloads
        bus_write(0, 1, 32'h4);
        wait_cycles(5);
        bus_write(0, 2, 32'd100);
        bus_read(0, 0, rd);
        check("ch0_stopped", rd, 32'd0);
        bus_write(0, 3, 32'd0);
        bus_read(0, 3, rd);
        check("ch0_snapshot_reload", rd, 32'd100);
        bus_write(0, 1, 32'hC);
        bus_read(0, 0, rd);
        check("ch0_start_wins", rd, 32'h2);

        // ch3: snapshot stability while counting
        bus_write(3, 2, 32'd50);
        bus_write(3, 1, 32'h6);
        wait_cycles(20);
        bus_write(3, 3, 32'd0);
        bus_read(3, 3, v1);
        check("ch3_snap_range", {31'd0, (v1 <= 32'd50)}, 32'd1);
        wait_cycles(7);
        bus_read(3, 3, rd);
        check("ch3_snap_stable", rd, v1);
        bus_read(3, 6, rd);
        check("ch3_off6_zero", rd, 32'd0);

        // asynchronous reset mid-count
        bus_write(1, 1, 32'h7);
        wait_cycles(4);
        @(negedge clk);
        reset = 1'b1;
        #2;
        check("midreset_readdata", readdata, 32'd0);
        check("midreset_irq", {28'd0, irq_ch}, 32'd0);
        @(negedge clk); #1;
        reset = 1'b0;
        bus_read(3, 2, rd);
        check("post_reset_period", rd, 32'd99999);
        bus_read(1, 0, rd);
        check("post_reset_status", rd, 32'd0);

        wait_cycles(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
